// File: rtl/posit_fault_responder.sv
// Fault responder for a reduced-precision posit adder: forwards clean sums and
// retries faulted ones on the full-width adder, flagging NaR when retries run out.
module posit_fault_responder #(
    parameter int FULL_NBITS = 32,
    parameter int MAX_RETRY  = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chk_valid,
    output logic                  chk_ready,
    input  logic                  chk_fault,
    input  logic [FULL_NBITS-1:0] chk_true_sum,
    output logic                  rc_req,
    input  logic                  rc_ack,
    input  logic [FULL_NBITS-1:0] rc_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FULL_NBITS-1:0] out_sum,
    output logic                  out_corrected,
    output logic                  out_err,
    output logic [15:0]           fault_count,
    output logic                  busy
);

    localparam int AW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FULL_NBITS-1:0] NAR = {1'b1, {(FULL_NBITS-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_OUT} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         attempt_q;
    logic [TW-1:0]         wait_q;
    logic [15:0]           fault_cnt_q;
    logic [FULL_NBITS-1:0] true_q;
    logic [FULL_NBITS-1:0] out_sum_q;
    logic                  out_corr_q;
    logic                  out_err_q;
    logic                  out_valid_q;

    logic accept;
    logic rc_match;
    logic timed_out;
    logic attempt_fail;
    logic last_attempt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept       = (state_q == S_IDLE) && chk_valid;
    assign rc_match     = rc_ack && (rc_sum == true_q);
    assign timed_out    = (wait_q == TW'(TIMEOUT - 1));
    // An ack arriving on the expiry cycle is judged on its sum, never as a timeout.
    assign attempt_fail = (state_q == S_REQ) && !rc_match && (rc_ack || timed_out);
    assign last_attempt = (attempt_q >= AW'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (chk_valid) state_d = chk_fault ? S_REQ : S_OUT;
            S_REQ: begin
                if (rc_match)          state_d = S_OUT;
                else if (attempt_fail) state_d = last_attempt ? S_OUT : S_GAP;
            end
            S_GAP:  state_d = S_REQ;
            S_OUT:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) true_q <= chk_true_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            attempt_q   <= '0;
            wait_q      <= '0;
            fault_cnt_q <= '0;
            out_sum_q   <= '0;
            out_corr_q  <= 1'b0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_d == S_OUT);
            case (state_q)
                S_IDLE: begin
                    if (chk_valid && !chk_fault) begin
                        out_sum_q  <= chk_true_sum;
                        out_corr_q <= 1'b0;
                        out_err_q  <= 1'b0;
                    end else if (chk_valid) begin
                        attempt_q   <= AW'(1);
                        wait_q      <= '0;
                        fault_cnt_q <= sat_inc16(fault_cnt_q);
                    end
                end
                S_REQ: begin
                    if (rc_match) begin
                        out_sum_q  <= rc_sum;
                        out_corr_q <= 1'b1;
                        out_err_q  <= 1'b0;
                    end else if (attempt_fail) begin
                        wait_q <= '0;
                        if (last_attempt) begin
                            out_sum_q  <= NAR;
                            out_corr_q <= 1'b0;
                            out_err_q  <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end
                S_GAP: begin
                    attempt_q <= attempt_q + AW'(1);
                    wait_q    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign chk_ready     = (state_q == S_IDLE);
    assign rc_req        = (state_q == S_REQ);
    assign busy          = (state_q != S_IDLE);
    assign out_valid     = out_valid_q;
    assign out_sum       = out_sum_q;
    assign out_corrected = out_corr_q;
    assign out_err       = out_err_q;
    assign fault_count   = fault_cnt_q;

endmodule

// File: doc/posit_fault_responder.md
POSIT_FAULT_RESPONDER -- requirements
Module: posit_fault_responder

Interface
REQ-001 SHALL have parameter FULL_NBITS, default 32, posit width of sums.
REQ-002 SHALL have parameter MAX_RETRY, default 2, maximum recompute attempts per faulted operation.
REQ-003 SHALL have parameter TIMEOUT, default 15, cycles to wait for rc_ack per attempt.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: chk_valid  in  1  checker verdict valid.
REQ-006 chk_ready  out  1  responder accepts verdict.
REQ-007 chk_fault  in  1  checker flagged fault.
REQ-008 chk_true_sum  in  FULL_NBITS  full-precision reference sum.
REQ-009 rc_req  out  1  recompute request to full-width adder.
REQ-010 rc_ack  in  1  recompute result valid.
REQ-011 rc_sum  in  FULL_NBITS  recomputed sum.
REQ-012 out_valid  out  1  final result valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 out_sum  out  FULL_NBITS  final posit result.
REQ-015 out_corrected  out  1  result came from a successful recompute.
REQ-016 out_err  out  1  unrecoverable: retries exhausted.
REQ-017 fault_count  out  16  saturating count of accepted faulted verdicts.
REQ-018 busy  out  1  state not IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, GAP, OUT.
REQ-020 chk_ready SHALL be 1 only in IDLE; verdict accepted when chk_valid & chk_ready at a clock edge; chk_fault and chk_true_sum captured at that edge.
REQ-021 IDLE, accept, chk_fault=0 -> OUT next cycle; out_sum=captured true sum, out_corrected=0, out_err=0.
REQ-022 IDLE, accept, chk_fault=1 -> REQ next cycle; attempt counter=1; wait counter=0; fault_count+1, saturating at 16'hFFFF.
REQ-023 rc_req SHALL equal 1 exactly while in REQ; wait counter increments each REQ cycle without rc_ack.
REQ-024 REQ with rc_ack=1 and rc_sum == captured true sum -> OUT; out_sum=rc_sum, out_corrected=1, out_err=0.
REQ-025 REQ with rc_ack=1 and mismatch, or wait counter reaching TIMEOUT-1 without rc_ack, is a failed attempt.
REQ-026 Failed attempt with attempt counter < MAX_RETRY -> GAP for exactly one cycle (rc_req=0), then REQ with attempt counter+1, wait counter=0.
REQ-027 Failed attempt with attempt counter == MAX_RETRY -> OUT; out_sum=NaR (MSB 1, rest 0), out_corrected=0, out_err=1.
REQ-028 rc_ack on the same cycle as timeout expiry SHALL be treated as an ack (ack wins).
REQ-029 rc_ack outside REQ SHALL be ignored.
REQ-030 OUT: out_valid=1; out_sum/out_corrected/out_err held stable until out_valid & out_ready; then IDLE next cycle.
REQ-031 Back-to-back throughput SHALL be one verdict per 2 cycles minimum (IDLE, OUT with out_ready=1).
REQ-032 Latency: no fault, accept at edge N -> out_valid at N+1; fault with rc_ack in first REQ cycle -> out_valid two cycles after accept.
REQ-033 All outputs SHALL be registered except chk_ready, rc_req, busy, which decode the state register.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE, counters 0, fault_count 0, out_sum 0, out_corrected 0, out_err 0, regardless of current state.
REQ-035 After reset: chk_ready=1, rc_req=0, out_valid=0, busy=0.
REQ-036 Reset during REQ SHALL drop rc_req the cycle after the reset edge; a later rc_ack SHALL be ignored.

Verification
REQ-037 No fault: chk_fault=0, true_sum=32'h4000_0000 accepted -> next cycle out_valid=1, out_sum=32'h4000_0000, corrected=0, err=0.
REQ-038 Fault recovered: chk_fault=1, true_sum=32'h3C00_0000; rc_ack on 3rd REQ cycle with rc_sum=32'h3C00_0000 -> out_sum=32'h3C00_0000, corrected=1, fault_count=1.
REQ-039 Mismatch then match: first rc_sum=32'h3C00_0001, one GAP cycle with rc_req=0, second rc_sum matches -> corrected=1, err=0.
REQ-040 Exhaustion: rc_ack never asserted, MAX_RETRY=2, TIMEOUT=15 -> rc_req high 15 cycles, low 1, high 15, then out_sum=32'h8000_0000, err=1.
REQ-041 Backpressure and saturation: out_ready=0 for 10 cycles -> outputs stable, chk_ready=0; fault_count preloaded via 65535 faulted verdicts stays 16'hFFFF on the next fault.
REQ-042 Reset mid-REQ: rst pulsed on 2nd REQ cycle -> next cycle rc_req=0, busy=0, fault_count=0; rc_ack asserted afterwards produces no out_valid.
